// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the shared ripple-slice ALU: issues single-pass ops,
// runs MUL as WIDTH shift-add passes, and holds the response until it is taken.
module alu_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_opc_i,
  input  logic [WIDTH-1:0] cmd_a_i,
  input  logic [WIDTH-1:0] cmd_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_carry_o,
  output logic             rsp_zero_o,
  output logic             rsp_err_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic             alu_ainvert_o,
  output logic             alu_bnegate_o,
  output logic             alu_cin_o,
  output logic [2:0]       alu_op_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_cout_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OPC_AND = 3'd0;
  localparam logic [2:0] OPC_OR  = 3'd1;
  localparam logic [2:0] OPC_ADD = 3'd2;
  localparam logic [2:0] OPC_SUB = 3'd3;
  localparam logic [2:0] OPC_XOR = 3'd4;
  localparam logic [2:0] OPC_NOR = 3'd5;
  localparam logic [2:0] OPC_MUL = 3'd6;
  localparam logic [2:0] OPC_ILL = 3'd7;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;

  logic [1:0]       state_q, state_d;
  logic [2:0]       opc_q, opc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] mul_acc_next;

  // During MUL, a_q doubles as the shifting multiplicand and b_q as the multiplier.
  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    err_d        = err_q;
    valid_d      = valid_q;
    mul_acc_next = b_q[0] ? alu_result_i : acc_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          opc_d = cmd_opc_i;
          a_d   = cmd_a_i;
          b_d   = cmd_b_i;
          acc_d = '0;
          cnt_d = '0;
          err_d = 1'b0;
          if (cmd_opc_i == OPC_ILL) begin
            res_d   = '0;
            carry_d = 1'b0;
            zero_d  = 1'b1;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (cmd_opc_i == OPC_MUL) begin
            state_d = S_MUL;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        res_d   = alu_result_i;
        carry_d = alu_cout_i;
        zero_d  = (alu_result_i == '0);
        state_d = S_DONE;
      end
      S_MUL: begin
        acc_d = mul_acc_next;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          res_d   = mul_acc_next;
          carry_d = 1'b0;
          zero_d  = (mul_acc_next == '0);
          state_d = S_DONE;
        end
      end
      default: begin
        // First DONE cycle only raises valid; the handshake is honoured from then on.
        valid_d = 1'b1;
        if (valid_q && rsp_ready_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  // ALU inputs are quiet outside EXEC/MUL so the shared datapath sees no stray activity.
  always_comb begin
    alu_a_o       = '0;
    alu_b_o       = '0;
    alu_ainvert_o = 1'b0;
    alu_bnegate_o = 1'b0;
    alu_cin_o     = 1'b0;
    alu_op_o      = ALU_AND;
    if (state_q == S_EXEC) begin
      alu_a_o = a_q;
      alu_b_o = b_q;
      case (opc_q)
        OPC_AND: alu_op_o = ALU_AND;
        OPC_OR:  alu_op_o = ALU_OR;
        OPC_ADD: alu_op_o = ALU_ADD;
        OPC_SUB: begin
          alu_bnegate_o = 1'b1;
          alu_cin_o     = 1'b1;
          alu_op_o      = ALU_ADD;
        end
        OPC_XOR: alu_op_o = ALU_XOR;
        OPC_NOR: begin
          alu_ainvert_o = 1'b1;
          alu_bnegate_o = 1'b1;
          alu_op_o      = ALU_AND;
        end
        default: alu_op_o = ALU_AND;
      endcase
    end else if (state_q == S_MUL) begin
      alu_a_o  = acc_q;
      alu_b_o  = a_q;
      alu_op_o = ALU_ADD;
    end
  end

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign rsp_valid_o  = valid_q;
  assign rsp_result_o = res_q;
  assign rsp_carry_o  = carry_q;
  assign rsp_zero_o   = zero_q;
  assign rsp_err_o    = err_q;

endmodule
